// File: rtl/booth_multiplier_controller_if.sv
// Request/result bundle between a requesting unit and the Booth multiplier controller.
// The requester (master) drives start and the operands; the controller (slave) returns status and product.
interface booth_multiplier_controller_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_multiplier_controller.sv
// Sequential signed multiplier using radix-2 Booth recoding: one add, subtract or pass per CALC cycle
// through a WIDTH+1-bit adder/subtracter, then an arithmetic shift of {A,Q,Q_1}.
module booth_multiplier_controller #(
  parameter int WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  booth_multiplier_controller_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_next;
  logic [WIDTH:0]       a, mx;
  logic [WIDTH-1:0]     q;
  logic                 q_1;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   product_q;

  logic                 sub, add_en, last_step;
  logic [WIDTH:0]       b_op, t, a_sh;
  logic [WIDTH-1:0]     q_sh;

  assign last_step = (cnt == CW'(1));

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path can infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Booth step: {Q[0],Q_1}=01 adds Mx, 10 subtracts it as A + ~Mx + 1, 00/11 pass A through.
  always_comb begin
    sub    = q[0] & ~q_1;
    add_en = q[0] ^ q_1;
    b_op   = add_en ? (mx ^ {(WIDTH+1){sub}}) : '0;
    t      = a + b_op + {{WIDTH{1'b0}}, sub};
    a_sh   = {t[WIDTH], t[WIDTH:1]};
    q_sh   = {t[0], q[WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a         <= '0;
      mx        <= '0;
      q         <= '0;
      q_1       <= 1'b0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a   <= '0;
            mx  <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
            q   <= bus.multiplier;
            q_1 <= 1'b0;
            cnt <= CW'(WIDTH);
          end
        end
        CALC: begin
          a   <= a_sh;
          q   <= q_sh;
          q_1 <= q[0];
          cnt <= cnt - CW'(1);
          // The product is taken from the final shifted values so it is valid in the DONE cycle.
          if (last_step) product_q <= {a_sh[WIDTH-1:0], q_sh};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state == CALC);
  assign bus.done    = (state == DONE);
  assign bus.product = product_q;

endmodule
